// File: rtl/cv32e40p_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// cv32e40p_pipe_stage_elastic
//
// Elastic pipeline stage register for inter-stage boundaries (ID/EX, EX/WB).
// Holds up to two entries: a main register that drives the outputs and a
// skid register that absorbs one extra entry. Because of the skid register,
// in_ready_o depends only on registered state and has no combinational path
// from out_ready_i.
//
// Each entry has NUM_LANES data lanes of DATA_W bits and a CTRL_W-bit control
// word. The control word is forced to zero whenever the output is a bubble.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush_i         drop every held entry and any entry accepted this cycle
//   in_valid_i      upstream entry valid
//   in_ready_o      stage can accept (registered)
//   in_data_i       lane data, lane k at [k*DATA_W +: DATA_W]
//   in_lane_we_i    per-lane capture enable
//   in_ctrl_i       control word
//   upd_en_i        overwrite one lane of the held output entry
//   upd_lane_i      lane to overwrite (out-of-range values are ignored)
//   upd_data_i      replacement data
//   out_valid_o     output entry valid
//   out_ready_i     downstream accepts
//   out_data_o      output lanes
//   out_ctrl_o      output control, zero when out_valid_o is low
//   occupancy_o     number of held entries (0..2)
//   parity_err_o    per-lane parity error
//
// Optional feature: define CV32E40P_PIPE_PARITY_EN to store an even-parity
// bit per lane for main and skid entries and report mismatches on
// parity_err_o. Without it parity_err_o is tied to zero.
// ---------------------------------------------------------------------------
module cv32e40p_pipe_stage_elastic #(
  parameter int DATA_W     = 32,
  parameter int NUM_LANES  = 4,
  parameter int CTRL_W     = 8,
  parameter int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data_i,
  input  logic [NUM_LANES-1:0]          in_lane_we_i,
  input  logic [CTRL_W-1:0]             in_ctrl_i,
  input  logic                          upd_en_i,
  input  logic [LANE_IDX_W-1:0]         upd_lane_i,
  input  logic [DATA_W-1:0]             upd_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NUM_LANES*DATA_W-1:0]   out_data_o,
  output logic [CTRL_W-1:0]             out_ctrl_o,
  output logic [1:0]                    occupancy_o,
  output logic [NUM_LANES-1:0]          parity_err_o
);

  // State number equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                        state_reg, state_next;

  logic [NUM_LANES*DATA_W-1:0]   main_data_reg, main_data_next;
  logic [CTRL_W-1:0]             main_ctrl_reg, main_ctrl_next;
  logic [NUM_LANES*DATA_W-1:0]   skid_data_reg;
  logic [NUM_LANES-1:0]          skid_mask_reg;
  logic [CTRL_W-1:0]             skid_ctrl_reg;

  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clear_ctrl;
  logic upd_ok;

  assign out_valid_o = (state_reg != ST_EMPTY);
  assign in_ready_o  = (state_reg != ST_FULL);
  assign occupancy_o = state_reg;
  assign out_data_o  = main_data_reg;
  assign out_ctrl_o  = main_ctrl_reg;

  assign accept = in_valid_i & in_ready_o;
  assign pop    = out_valid_o & out_ready_i;

  // In-place update only touches a held entry that is not leaving this cycle.
  assign upd_ok = upd_en_i & out_valid_o & ~pop & ~flush_i;

  // -------------------------------------------------------------------------
  // Next-state and load control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_ctrl     = 1'b0;

    if (flush_i) begin
      // Anything accepted in the flush cycle is dropped: no load flag is set.
      state_next = ST_EMPTY;
      clear_ctrl = 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_next = ST_FULL;
            load_skid  = 1'b1;
          end else if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (pop) begin
            state_next = ST_EMPTY;
            clear_ctrl = 1'b1;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_next     = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          clear_ctrl = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    main_ctrl_next = main_ctrl_reg;
    if (clear_ctrl) begin
      main_ctrl_next = '0;
    end else if (load_main_in) begin
      main_ctrl_next = in_ctrl_i;
    end else if (load_main_skid) begin
      main_ctrl_next = skid_ctrl_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Per-lane data path: gated capture from input or skid, or in-place update
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic upd_hit;
      // Lanes beyond NUM_LANES have no generate instance, so an out-of-range
      // upd_lane_i never matches and the update is ignored.
      assign upd_hit = upd_ok && (upd_lane_i == LANE_IDX_W'(gi));

      always_comb begin
        main_data_next[gi*DATA_W +: DATA_W] = main_data_reg[gi*DATA_W +: DATA_W];
        if (load_main_in && in_lane_we_i[gi]) begin
          main_data_next[gi*DATA_W +: DATA_W] = in_data_i[gi*DATA_W +: DATA_W];
        end else if (load_main_skid && skid_mask_reg[gi]) begin
          main_data_next[gi*DATA_W +: DATA_W] = skid_data_reg[gi*DATA_W +: DATA_W];
        end else if (upd_hit) begin
          main_data_next[gi*DATA_W +: DATA_W] = upd_data_i;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_mask_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      if (load_skid) begin
        // The whole input is stored; the mask decides later which lanes land.
        skid_data_reg <= in_data_i;
        skid_mask_reg <= in_lane_we_i;
        skid_ctrl_reg <= in_ctrl_i;
      end
    end
  end

`ifdef CV32E40P_PIPE_PARITY_EN
  // -------------------------------------------------------------------------
  // Even parity per lane, tracked alongside main and skid data
  // -------------------------------------------------------------------------
  logic [NUM_LANES-1:0] main_par_reg, main_par_next;
  logic [NUM_LANES-1:0] skid_par_reg, skid_par_next;

  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_par
      always_comb begin
        // Same priority as the data path so a gated lane keeps its parity.
        main_par_next[gi] = main_par_reg[gi];
        if (load_main_in && in_lane_we_i[gi]) begin
          main_par_next[gi] = ^in_data_i[gi*DATA_W +: DATA_W];
        end else if (load_main_skid && skid_mask_reg[gi]) begin
          main_par_next[gi] = skid_par_reg[gi];
        end else if (g_lane[gi].upd_hit) begin
          main_par_next[gi] = ^upd_data_i;
        end
      end

      assign skid_par_next[gi] = ^in_data_i[gi*DATA_W +: DATA_W];

      assign parity_err_o[gi] = out_valid_o &
                                (^main_data_reg[gi*DATA_W +: DATA_W] ^ main_par_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_par_reg <= '0;
      skid_par_reg <= '0;
    end else begin
      main_par_reg <= main_par_next;
      if (load_skid) begin
        skid_par_reg <= skid_par_next;
      end
    end
  end
`else
  assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_pipe_stage_elastic
//
// Directed testbench for cv32e40p_pipe_stage_elastic with DATA_W=32,
// NUM_LANES=2, CTRL_W=4. Expected values are written by hand next to each
// stimulus step.
// ---------------------------------------------------------------------------
module tb_cv32e40p_pipe_stage_elastic;

  localparam int DATA_W     = 32;
  localparam int NUM_LANES  = 2;
  localparam int CTRL_W     = 4;
  localparam int LANE_IDX_W = 1;

  logic                        clk;
  logic                        rst_n;
  logic                        flush_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [NUM_LANES*DATA_W-1:0] in_data_i;
  logic [NUM_LANES-1:0]        in_lane_we_i;
  logic [CTRL_W-1:0]           in_ctrl_i;
  logic                        upd_en_i;
  logic [LANE_IDX_W-1:0]       upd_lane_i;
  logic [DATA_W-1:0]           upd_data_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [NUM_LANES*DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0]           out_ctrl_o;
  logic [1:0]                  occupancy_o;
  logic [NUM_LANES-1:0]        parity_err_o;

  int checks_cnt = 0;
  int errors_cnt = 0;

  cv32e40p_pipe_stage_elastic #(
    .DATA_W     (DATA_W),
    .NUM_LANES  (NUM_LANES),
    .CTRL_W     (CTRL_W),
    .LANE_IDX_W (LANE_IDX_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_lane_we_i (in_lane_we_i),
    .in_ctrl_i    (in_ctrl_i),
    .upd_en_i     (upd_en_i),
    .upd_lane_i   (upd_lane_i),
    .upd_data_i   (upd_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_ctrl_o   (out_ctrl_o),
    .occupancy_o  (occupancy_o),
    .parity_err_o (parity_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic push(input logic [63:0] data, input logic [1:0] mask, input logic [3:0] ctrl);
    in_valid_i   = 1'b1;
    in_data_i    = data;
    in_lane_we_i = mask;
    in_ctrl_i    = ctrl;
  endtask

  initial begin
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    in_data_i    = '0;
    in_lane_we_i = '0;
    in_ctrl_i    = '0;
    upd_en_i     = 1'b0;
    upd_lane_i   = '0;
    upd_data_i   = '0;
    out_ready_i  = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_data",  out_data_o,       64'd0);
    check("rst_ctrl",  64'(out_ctrl_o),  64'd0);
    check("rst_occ",   64'(occupancy_o), 64'd0);
    check("rst_ready", 64'(in_ready_o),  64'd1);
    check("rst_par",   64'(parity_err_o), 64'd0);

    // 1. Single transfer, latency 1
    out_ready_i = 1'b1;
    push({32'hB, 32'hA}, 2'b11, 4'h5);
    step();
    in_valid_i = 1'b0;
    check("t1_valid", 64'(out_valid_o), 64'd1);
    check("t1_data",  out_data_o,       {32'hB, 32'hA});
    check("t1_ctrl",  64'(out_ctrl_o),  64'd5);
    check("t1_occ",   64'(occupancy_o), 64'd1);
    step();  // popped with no refill -> bubble
    check("t1_bub_valid", 64'(out_valid_o), 64'd0);
    check("t1_bub_ctrl",  64'(out_ctrl_o),  64'd0);
    check("t1_bub_data",  out_data_o,       {32'hB, 32'hA});

    // 2. Backpressure fills the skid, then FIFO drain
    out_ready_i = 1'b0;
    push({32'h1, 32'h1}, 2'b11, 4'h1);
    step();
    check("t2_occ1",   64'(occupancy_o), 64'd1);
    check("t2_rdy1",   64'(in_ready_o),  64'd1);
    push({32'h2, 32'h2}, 2'b11, 4'h2);
    step();
    check("t2_occ2",   64'(occupancy_o), 64'd2);
    check("t2_rdy2",   64'(in_ready_o),  64'd0);
    push({32'h3, 32'h3}, 2'b11, 4'h3);
    step();  // third entry held upstream
    check("t2_hold_occ",  64'(occupancy_o), 64'd2);
    check("t2_hold_ctrl", 64'(out_ctrl_o),  64'd1);
    out_ready_i = 1'b1;
    step();  // pop 1, main <- skid (2)
    check("t2_pop2_ctrl", 64'(out_ctrl_o),  64'd2);
    check("t2_pop2_occ",  64'(occupancy_o), 64'd1);
    step();  // pop 2, accept 3
    in_valid_i = 1'b0;
    check("t2_pop3_ctrl", 64'(out_ctrl_o),  64'd3);
    check("t2_pop3_data", out_data_o,       {32'h3, 32'h3});
    step();  // pop 3
    check("t2_empty_valid", 64'(out_valid_o), 64'd0);
    check("t2_empty_occ",   64'(occupancy_o), 64'd0);

    // Full throughput: back-to-back entries with out_ready held high
    for (int k = 4; k < 7; k++) begin
      push({32'(k), 32'(k)}, 2'b11, 4'(k));
      step();
      check($sformatf("stream_ctrl%0d", k), 64'(out_ctrl_o), 64'(k));
      check($sformatf("stream_rdy%0d", k),  64'(in_ready_o), 64'd1);
    end
    in_valid_i = 1'b0;
    step();

    // 3. Lane gating, direct path
    out_ready_i = 1'b0;
    push({32'hB, 32'hA}, 2'b11, 4'h5);
    step();
    check("t3_base", out_data_o, {32'hB, 32'hA});
    out_ready_i = 1'b1;
    push({32'hD, 32'hC}, 2'b01, 4'h6);
    step();
    in_valid_i = 1'b0;
    check("t3_direct_data", out_data_o,      {32'hB, 32'hC});
    check("t3_direct_ctrl", 64'(out_ctrl_o), 64'd6);
    step();

    // Lane gating through the skid path
    out_ready_i = 1'b0;
    push({32'hB, 32'hA}, 2'b11, 4'h5);
    step();
    push({32'hD, 32'hC}, 2'b01, 4'h7);
    step();
    in_valid_i = 1'b0;
    check("t3_skid_occ",  64'(occupancy_o), 64'd2);
    check("t3_skid_main", out_data_o,       {32'hB, 32'hA});
    out_ready_i = 1'b1;
    step();
    check("t3_skid_data", out_data_o,       {32'hB, 32'hC});
    check("t3_skid_ctrl", 64'(out_ctrl_o),  64'd7);
    check("t3_skid_occ1", 64'(occupancy_o), 64'd1);
    step();
    out_ready_i = 1'b0;

    // 4. In-place update
    push({32'hB, 32'hA}, 2'b11, 4'h5);
    step();
    in_valid_i = 1'b0;
    upd_en_i   = 1'b1;
    upd_lane_i = 1'b1;
    upd_data_i = 32'h4;
    step();
    upd_en_i = 1'b0;
    check("t4_upd_data",  out_data_o,       {32'h4, 32'hA});
    check("t4_upd_valid", 64'(out_valid_o), 64'd1);
    check("t4_upd_par",   64'(parity_err_o), 64'd0);
    upd_en_i    = 1'b1;
    upd_lane_i  = 1'b0;
    upd_data_i  = 32'h9;
    out_ready_i = 1'b1;
    step();  // popping: update ignored
    upd_en_i    = 1'b0;
    out_ready_i = 1'b0;
    check("t4_pop_valid", 64'(out_valid_o), 64'd0);
    check("t4_pop_data",  out_data_o,       {32'h4, 32'hA});

    // 5. Flush while FULL with an input pending
    push({32'h1, 32'h1}, 2'b11, 4'h1);
    step();
    push({32'h2, 32'h2}, 2'b11, 4'h2);
    step();
    check("t5_full", 64'(occupancy_o), 64'd2);
    push({32'h3, 32'h3}, 2'b11, 4'h3);
    flush_i = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("t5_fl_valid", 64'(out_valid_o), 64'd0);
    check("t5_fl_ctrl",  64'(out_ctrl_o),  64'd0);
    check("t5_fl_occ",   64'(occupancy_o), 64'd0);
    check("t5_fl_rdy",   64'(in_ready_o),  64'd1);
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t5_no_ghost%0d", k), 64'(out_valid_o), 64'd0);
    end

    // Flush drops an entry accepted in the same cycle
    out_ready_i = 1'b0;
    push({32'h4, 32'h4}, 2'b11, 4'h4);
    step();
    push({32'h5, 32'h5}, 2'b11, 4'h5);
    flush_i = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("t5_acc_occ", 64'(occupancy_o), 64'd0);
    step();
    check("t5_acc_valid", 64'(out_valid_o), 64'd0);

    // Reset mid-stream
    push({32'h6, 32'h6}, 2'b11, 4'h6);
    step();
    push({32'h7, 32'h7}, 2'b11, 4'h7);
    step();
    rst_n = 1'b0;
    step();
    check("t5_rst_valid", 64'(out_valid_o), 64'd0);
    check("t5_rst_data",  out_data_o,       64'd0);
    check("t5_rst_ctrl",  64'(out_ctrl_o),  64'd0);
    check("t5_rst_occ",   64'(occupancy_o), 64'd0);
    check("t5_rst_rdy",   64'(in_ready_o),  64'd1);
    rst_n      = 1'b1;
    in_valid_i = 1'b0;
    step();
    check("t5_rst_after", 64'(out_valid_o), 64'd0);

    // 6. Parity
    push({32'hB, 32'hA}, 2'b11, 4'h5);
    step();
    in_valid_i = 1'b0;
    check("t6_par_clean", 64'(parity_err_o), 64'd0);
`ifdef CV32E40P_PIPE_PARITY_EN
    force dut.main_data_reg = {32'hB, 32'hB};  // one bit flipped in lane 0
    #1;
    check("t6_par_err", 64'(parity_err_o), 64'b01);
    release dut.main_data_reg;
`else
    step();
    check("t6_par_off", 64'(parity_err_o), 64'd0);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
